generation_clock_synthesis: RTL and testbench
=============================================

Name: generation_clock_synthesis

Overview:
Transmit-side counterpart of the recovery path. It synthesizes an outbound clock on clk_i from programmed high and low phase lengths, measured in clk_i cycles, with a selectable idle level. Start and stop are glitch-free, and start and stop happen only at whole-period boundaries. Rate changes are applied only at period boundaries. It emits per-edge event pulses in the same form the recovery path consumes (rising, falling, any edge), so local logic can launch data against the generated clock.

Parameters:
RATE_WIDTH, clks_alot_p::RATE_COUNTER_WIDTH, width of the phase-length inputs and internal counter.

Ports:
clk_i  input  1  system clock
sync_rst_i  input  1  synchronous active-high reset
enable_i  input  1  level; run the generated clock while high
idle_polarity_i  input  1  idle level of clk_o; sampled only in IDLE
high_rate_i  input  RATE_WIDTH  high-phase length in clk_i cycles; sampled with update_rate_i
low_rate_i  input  RATE_WIDTH  low-phase length in clk_i cycles; sampled with update_rate_i
update_rate_i  input  1  pulse; request load of high_rate_i and low_rate_i
clk_o  output  1  generated clock, registered
rising_edge_o  output  1  pulse in the cycle clk_o first reads 1
falling_edge_o  output  1  pulse in the cycle clk_o first reads 0
any_valid_edge_o  output  1  rising_edge_o OR falling_edge_o
running_o  output  1  high in every state except IDLE
rate_update_ack_o  output  1  pulse in the cycle the new rates become active
rate_error_o  output  1  pulse, one cycle after an update carrying a zero rate

Behaviour:
- Reset (synchronous, dominant over all other inputs, including mid-period):
  - State IDLE; clk_o=0; active rates=0; pending update cleared.
  - All pulse outputs 0; running_o=0; counter 0.
  - Mid-period reset may truncate a phase; this is accepted.
- State machine states:
  - IDLE: clk_o <= idle_polarity_i every cycle.
  - ACTIVE: clk_o at the non-idle level.
  - RETURN: clk_o at the idle level, inside a period.
- Active phase lengths:
  - ACTIVE length = high_rate when idle_polarity=0, low_rate when idle_polarity=1.
  - RETURN takes the other rate.
  - The idle polarity is latched on leaving IDLE and held until the next IDLE.
- IDLE -> ACTIVE:
  - Condition: enable_i=1 and both active rates nonzero.
  - clk_o toggles in the next cycle (1-cycle latency); the matching edge pulse fires in that cycle.
  - Counter loads ACTIVE length-1.
  - enable_i=1 with a zero active rate: remain in IDLE; no error pulse.
- ACTIVE, counter==0: toggle clk_o, enter RETURN, load RETURN length-1. Otherwise decrement.
- RETURN, counter==0 (period boundary):
  - Pending update, if any, becomes active; rate_update_ack_o pulses.
  - enable_i=1: toggle, enter ACTIVE, load the new ACTIVE length-1.
  - enable_i=0: enter IDLE, no toggle, so clk_o remains at the idle level (no runt pulse).
  - Otherwise decrement.
- enable_i deassertion inside a period never shortens it; the current period always completes.
- Output period = high_rate+low_rate cycles. Each phase lasts exactly its rate, minimum 1 (toggling every cycle when both rates are 1).
- Rate updates:
  - Zero in either field: discarded entirely; rate_error_o pulses next cycle; active and pending rates unchanged.
  - In IDLE: applied next cycle; ack pulses next cycle.
  - While running: stored as pending, and a later update overwrites an earlier pending one. Applied at the next period boundary.
  - Update in the same cycle as a boundary: bypasses pending and is used for that boundary's reload. Ack pulses in the cycle the reload occurs.
- Edge pulses are registered alongside clk_o and are mutually exclusive. No pulses in IDLE, including when idle_polarity_i changes the idle level.

Test Plan:
- Reset, update high=3 low=2, enable=1, idle_polarity=0 -> clk_o rises 1 cycle after enable; pattern 1,1,1,0,0 repeating; rising_edge_o every 5 cycles; running_o=1.
- high=1 low=1, idle_polarity=1 -> clk_o starts by falling and toggles every cycle; edge pulses every cycle, alternating falling/rising.
- Running 3/2; drop enable_i during the high phase -> the period completes, clk_o ends at 0 with no extra rising edge; IDLE and running_o=0 after the low phase.
- Running 3/2; update to 4/4 mid-high phase -> old period finishes at 5 cycles; ack at the boundary; next period 8 cycles (4 high, 4 low).
- Update with high=0 -> rate_error_o pulses next cycle; no ack; period unchanged; from reset, enable keeps clk_o at idle level.
- Assert sync_rst_i mid-period with idle_polarity=1 -> next cycle clk_o=0, all pulses 0, rates 0; enable alone does not restart until a valid update.

Source files
------------

// File: rtl/generation_clock_synthesis.sv
// ---------------------------------------------------------------------------
// generation_clock_synthesis
// Synthesizes an outbound clock on clk_i from programmed high/low phase
// lengths (in clk_i cycles) with a selectable idle level. Starts and stops
// only on whole-period boundaries; rate changes take effect at a boundary.
// Emits registered per-edge pulses in the same form the recovery path uses.
//
// Ports:
//   clk_i             system clock
//   sync_rst_i        synchronous active-high reset
//   enable_i          run the generated clock while high
//   idle_polarity_i   idle level of clk_o, sampled in IDLE
//   high_rate_i       high-phase length, sampled with update_rate_i
//   low_rate_i        low-phase length, sampled with update_rate_i
//   update_rate_i     pulse, request load of both rates
//   clk_o             generated clock
//   rising_edge_o     pulse in the cycle clk_o first reads 1
//   falling_edge_o    pulse in the cycle clk_o first reads 0
//   any_valid_edge_o  rising_edge_o | falling_edge_o
//   running_o         high in every state except IDLE
//   rate_update_ack_o pulse in the cycle the new rates become active
//   rate_error_o      pulse one cycle after an update carrying a zero rate
// ---------------------------------------------------------------------------
module generation_clock_synthesis #(
   parameter int unsigned RATE_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  sync_rst_i,
   input  logic                  enable_i,
   input  logic                  idle_polarity_i,
   input  logic [RATE_WIDTH-1:0] high_rate_i,
   input  logic [RATE_WIDTH-1:0] low_rate_i,
   input  logic                  update_rate_i,
   output logic                  clk_o,
   output logic                  rising_edge_o,
   output logic                  falling_edge_o,
   output logic                  any_valid_edge_o,
   output logic                  running_o,
   output logic                  rate_update_ack_o,
   output logic                  rate_error_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_RETURN = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [RATE_WIDTH-1:0] r_cnt;
   logic                  r_pol;
   logic [RATE_WIDTH-1:0] r_high;
   logic [RATE_WIDTH-1:0] r_low;
   logic [RATE_WIDTH-1:0] r_pend_high;
   logic [RATE_WIDTH-1:0] r_pend_low;
   logic                  r_pend_valid;
   logic                  r_clk;
   logic                  r_rise;
   logic                  r_fall;
   logic                  r_any;
   logic                  r_running;
   logic                  r_ack;
   logic                  r_err;

   logic                  w_upd_ok;
   logic                  w_upd_bad;
   logic                  w_start;
   logic                  w_cnt_zero;
   logic                  w_pol_now;
   logic [RATE_WIDTH-1:0] w_eff_high;
   logic [RATE_WIDTH-1:0] w_eff_low;
   logic [RATE_WIDTH-1:0] w_act_len;
   logic [RATE_WIDTH-1:0] w_ret_len;

   logic [RATE_WIDTH-1:0] w_cnt_nxt;
   logic                  w_pol_nxt;
   logic [RATE_WIDTH-1:0] w_high_nxt;
   logic [RATE_WIDTH-1:0] w_low_nxt;
   logic [RATE_WIDTH-1:0] w_pend_high_nxt;
   logic [RATE_WIDTH-1:0] w_pend_low_nxt;
   logic                  w_pend_valid_nxt;
   logic                  w_clk_nxt;
   logic                  w_ack_nxt;
   logic                  w_edge;

   // An update with a zero in either field is discarded and flagged.
   assign w_upd_ok   = update_rate_i && (high_rate_i != '0) && (low_rate_i != '0);
   assign w_upd_bad  = update_rate_i && !w_upd_ok;
   assign w_start    = enable_i && (r_high != '0) && (r_low != '0);
   assign w_cnt_zero = (r_cnt == '0);

   // Rates used for a reload: a same-cycle update bypasses the pending slot.
   always_comb begin
      w_eff_high = r_high;
      w_eff_low  = r_low;
      if (w_upd_ok) begin
         w_eff_high = high_rate_i;
         w_eff_low  = low_rate_i;
      end else if (r_pend_valid) begin
         w_eff_high = r_pend_high;
         w_eff_low  = r_pend_low;
      end
   end

   // Polarity is live in IDLE and frozen once a run has started.
   assign w_pol_now = (r_state == S_IDLE) ? idle_polarity_i : r_pol;
   assign w_act_len = w_pol_now ? w_eff_low : w_eff_high;
   assign w_ret_len = r_pol ? r_high : r_low;

   // State register.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (w_cnt_zero) w_state_nxt = S_RETURN;
         S_RETURN: if (w_cnt_zero) w_state_nxt = enable_i ? S_ACTIVE : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      w_cnt_nxt        = r_cnt;
      w_pol_nxt        = r_pol;
      w_high_nxt       = r_high;
      w_low_nxt        = r_low;
      w_pend_high_nxt  = r_pend_high;
      w_pend_low_nxt   = r_pend_low;
      w_pend_valid_nxt = r_pend_valid;
      w_clk_nxt        = r_clk;
      w_ack_nxt        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clk_nxt = idle_polarity_i;
            w_cnt_nxt = '0;
            // Rates written in IDLE are active next cycle; a start in the
            // same cycle already reloads from them.
            if (w_upd_ok) begin
               w_high_nxt = high_rate_i;
               w_low_nxt  = low_rate_i;
               w_ack_nxt  = 1'b1;
            end
            if (w_start) begin
               w_pol_nxt = idle_polarity_i;
               w_clk_nxt = ~idle_polarity_i;
               w_cnt_nxt = w_act_len - RATE_WIDTH'(1);
            end
         end
         S_ACTIVE: begin
            if (w_cnt_zero) begin
               w_clk_nxt = r_pol;
               w_cnt_nxt = w_ret_len - RATE_WIDTH'(1);
            end else begin
               w_cnt_nxt = r_cnt - RATE_WIDTH'(1);
            end
            if (w_upd_ok) begin
               w_pend_high_nxt  = high_rate_i;
               w_pend_low_nxt   = low_rate_i;
               w_pend_valid_nxt = 1'b1;
            end
         end
         S_RETURN: begin
            if (w_cnt_zero) begin
               // Period boundary: commit any new rates, then restart or park.
               w_high_nxt       = w_eff_high;
               w_low_nxt        = w_eff_low;
               w_ack_nxt        = w_upd_ok || r_pend_valid;
               w_pend_valid_nxt = 1'b0;
               if (enable_i) begin
                  w_clk_nxt = ~r_pol;
                  w_cnt_nxt = w_act_len - RATE_WIDTH'(1);
               end else begin
                  w_cnt_nxt = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt - RATE_WIDTH'(1);
               if (w_upd_ok) begin
                  w_pend_high_nxt  = high_rate_i;
                  w_pend_low_nxt   = low_rate_i;
                  w_pend_valid_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_cnt_nxt = '0;
         end
      endcase
   end

   // Level changes inside IDLE (polarity tracking) never produce pulses.
   assign w_edge = (w_state_nxt != S_IDLE) && (w_clk_nxt != r_clk);

   // Datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         r_cnt        <= '0;
         r_pol        <= 1'b0;
         r_high       <= '0;
         r_low        <= '0;
         r_pend_high  <= '0;
         r_pend_low   <= '0;
         r_pend_valid <= 1'b0;
         r_clk        <= 1'b0;
         r_rise       <= 1'b0;
         r_fall       <= 1'b0;
         r_any        <= 1'b0;
         r_running    <= 1'b0;
         r_ack        <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_pol        <= w_pol_nxt;
         r_high       <= w_high_nxt;
         r_low        <= w_low_nxt;
         r_pend_high  <= w_pend_high_nxt;
         r_pend_low   <= w_pend_low_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_clk        <= w_clk_nxt;
         r_rise       <= w_edge && w_clk_nxt;
         r_fall       <= w_edge && !w_clk_nxt;
         r_any        <= w_edge;
         r_running    <= (w_state_nxt != S_IDLE);
         r_ack        <= w_ack_nxt;
         r_err        <= w_upd_bad;
      end
   end

   assign clk_o             = r_clk;
   assign rising_edge_o     = r_rise;
   assign falling_edge_o    = r_fall;
   assign any_valid_edge_o  = r_any;
   assign running_o         = r_running;
   assign rate_update_ack_o = r_ack;
   assign rate_error_o      = r_err;

endmodule

// File: tb/tb_generation_clock_synthesis.sv
// ---------------------------------------------------------------------------
// tb_generation_clock_synthesis
// Directed scenarios with hand-written expected waveforms, followed by a
// randomized run; every cycle the DUT is compared against a position-in-
// period model of the generated clock.
// ---------------------------------------------------------------------------
module tb_generation_clock_synthesis;

   localparam int unsigned RW = 8;

   logic          clk_i = 1'b0;
   logic          sync_rst_i;
   logic          enable_i;
   logic          idle_polarity_i;
   logic [RW-1:0] high_rate_i;
   logic [RW-1:0] low_rate_i;
   logic          update_rate_i;
   logic          clk_o;
   logic          rising_edge_o;
   logic          falling_edge_o;
   logic          any_valid_edge_o;
   logic          running_o;
   logic          rate_update_ack_o;
   logic          rate_error_o;

   int n_cmp = 0;
   int n_bad = 0;

   generation_clock_synthesis #(.RATE_WIDTH(RW)) dut (
      .clk_i             (clk_i),
      .sync_rst_i        (sync_rst_i),
      .enable_i          (enable_i),
      .idle_polarity_i   (idle_polarity_i),
      .high_rate_i       (high_rate_i),
      .low_rate_i        (low_rate_i),
      .update_rate_i     (update_rate_i),
      .clk_o             (clk_o),
      .rising_edge_o     (rising_edge_o),
      .falling_edge_o    (falling_edge_o),
      .any_valid_edge_o  (any_valid_edge_o),
      .running_o         (running_o),
      .rate_update_ack_o (rate_update_ack_o),
      .rate_error_o      (rate_error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A run is a sequence of periods; within a period the output is at the
   // non-idle level for the first m_a cycles and at the idle level for m_r.
   bit m_valid = 1'b0;
   bit m_run, m_pol, m_pv;
   int m_pos, m_a, m_r, m_h, m_l, m_ph, m_pl;
   bit e_clk, e_rise, e_fall, e_run, e_ack, e_err;

   always @(posedge clk_i) begin
      bit ok, prev, was_run;
      int nh, nl;
      if (sync_rst_i) begin
         m_valid = 1'b1;
         m_run = 0; m_pol = 0; m_pv = 0; m_pos = 0; m_a = 0; m_r = 0;
         m_h = 0; m_l = 0; m_ph = 0; m_pl = 0;
         e_clk = 0; e_rise = 0; e_fall = 0; e_run = 0; e_ack = 0; e_err = 0;
      end else begin
         ok      = update_rate_i && (high_rate_i != 0) && (low_rate_i != 0);
         e_err   = update_rate_i && !ok;
         e_ack   = 0;
         prev    = e_clk;
         was_run = m_run;
         nh = ok ? int'(high_rate_i) : m_h;
         nl = ok ? int'(low_rate_i)  : m_l;
         if (!m_run) begin
            if (enable_i && m_h != 0 && m_l != 0) begin
               m_pol = idle_polarity_i;
               m_a = m_pol ? nl : nh;
               m_r = m_pol ? nh : nl;
               m_pos = 0;
               m_run = 1;
            end
            if (ok) begin m_h = nh; m_l = nl; e_ack = 1; end
         end else if (m_pos == m_a + m_r - 1) begin
            if (!ok && m_pv) begin nh = m_ph; nl = m_pl; end
            e_ack = ok || m_pv;
            m_h = nh; m_l = nl; m_pv = 0;
            if (enable_i) begin
               m_pos = 0;
               m_a = m_pol ? nl : nh;
               m_r = m_pol ? nh : nl;
            end else begin
               m_run = 0;
            end
         end else begin
            m_pos++;
            if (ok) begin m_ph = nh; m_pl = nl; m_pv = 1; end
         end
         if (m_run)        e_clk = (m_pos < m_a) ? !m_pol : m_pol;
         else if (was_run) e_clk = m_pol;
         else              e_clk = idle_polarity_i;
         e_run  = m_run;
         e_rise = m_run && (e_clk != prev) && e_clk;
         e_fall = m_run && (e_clk != prev) && !e_clk;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk_i) begin
      if (m_valid) begin
         chk("m_clk",  clk_o,             e_clk);
         chk("m_rise", rising_edge_o,     e_rise);
         chk("m_fall", falling_edge_o,    e_fall);
         chk("m_any",  any_valid_edge_o,  e_rise | e_fall);
         chk("m_run",  running_o,         e_run);
         chk("m_ack",  rate_update_ack_o, e_ack);
         chk("m_err",  rate_error_o,      e_err);
      end
   end

   // Literal waveform check; masks are MSB-first in time.
   task automatic check_seq(input string tag, input int n,
                            input logic [15:0] p_clk, input logic [15:0] p_rise,
                            input logic [15:0] p_fall, input logic [15:0] p_run,
                            input logic [15:0] p_ack);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         chk({tag, "_clk"},  clk_o,             p_clk[n-1-i]);
         chk({tag, "_rise"}, rising_edge_o,     p_rise[n-1-i]);
         chk({tag, "_fall"}, falling_edge_o,    p_fall[n-1-i]);
         chk({tag, "_any"},  any_valid_edge_o,  p_rise[n-1-i] | p_fall[n-1-i]);
         chk({tag, "_run"},  running_o,         p_run[n-1-i]);
         chk({tag, "_ack"},  rate_update_ack_o, p_ack[n-1-i]);
      end
   endtask

   task automatic set_update(input int h, input int l);
      update_rate_i = 1'b1;
      high_rate_i   = RW'(h);
      low_rate_i    = RW'(l);
      @(negedge clk_i);
      update_rate_i = 1'b0;
   endtask

   initial begin
      sync_rst_i = 1'b1; enable_i = 1'b0; idle_polarity_i = 1'b0;
      high_rate_i = '0; low_rate_i = '0; update_rate_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_clk", clk_o, 1'b0);
      chk("rst_run", running_o, 1'b0);
      chk("rst_any", any_valid_edge_o, 1'b0);
      sync_rst_i = 1'b0;

      // 3/2, idle low: 1,1,1,0,0 repeating
      set_update(3, 2);
      chk("A_ack", rate_update_ack_o, 1'b1);
      enable_i = 1'b1;
      check_seq("A", 11, 16'b11100111001, 16'b10000100001, 16'b00010000100,
                16'b11111111111, 16'b0);

      // enable dropped in the high phase: period completes, no runt
      enable_i = 1'b0;
      check_seq("F", 5, 16'b11000, 16'b0, 16'b00100, 16'b11110, 16'b0);

      // 3/2 then update to 4/4 mid-high: applied at the boundary
      enable_i = 1'b1;
      check_seq("E0", 2, 16'b11, 16'b10, 16'b0, 16'b11, 16'b0);
      set_update(4, 4);
      chk("E_mid_clk", clk_o, 1'b1);
      chk("E_mid_ack", rate_update_ack_o, 1'b0);
      check_seq("E", 11, 16'b00111100001, 16'b00100000001, 16'b10000010000,
                16'b11111111111, 16'b00100000000);

      // 1/1, idle high: falls first, toggles every cycle
      sync_rst_i = 1'b1; enable_i = 1'b0; idle_polarity_i = 1'b1;
      @(negedge clk_i);
      sync_rst_i = 1'b0;
      set_update(1, 1);
      chk("B_idle_clk", clk_o, 1'b1);
      chk("B_ack", rate_update_ack_o, 1'b1);
      enable_i = 1'b1;
      check_seq("B", 6, 16'b010101, 16'b010101, 16'b101010, 16'b111111, 16'b0);

      // reset mid-period with idle high; enable alone must not restart
      sync_rst_i = 1'b1;
      @(negedge clk_i);
      sync_rst_i = 1'b0;
      chk("D_clk", clk_o, 1'b0);
      chk("D_run", running_o, 1'b0);
      chk("D_any", any_valid_edge_o, 1'b0);
      check_seq("D", 4, 16'b1111, 16'b0, 16'b0, 16'b0, 16'b0);

      // zero-rate update: error, no ack, no start
      set_update(0, 2);
      chk("C_err", rate_error_o, 1'b1);
      chk("C_ack", rate_update_ack_o, 1'b0);
      chk("C_run", running_o, 1'b0);
      set_update(3, 2);
      chk("C_ack2", rate_update_ack_o, 1'b1);
      chk("C_run2", running_o, 1'b0);
      check_seq("C0", 1, 16'b0, 16'b0, 16'b1, 16'b1, 16'b0);
      set_update(5, 0);
      chk("C_err2", rate_error_o, 1'b1);
      chk("C_c1", clk_o, 1'b0);
      check_seq("C", 6, 16'b111001, 16'b100001, 16'b000100, 16'b111111, 16'b0);

      // randomized run
      for (int c = 0; c < 4000; c++) begin
         sync_rst_i    = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 24) == 0) enable_i = ~enable_i;
         if ($urandom_range(0, 14) == 0) idle_polarity_i = ~idle_polarity_i;
         update_rate_i = ($urandom_range(0, 7) == 0);
         high_rate_i   = RW'($urandom_range(0, 5));
         low_rate_i    = RW'($urandom_range(0, 5));
         @(negedge clk_i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
